// File: rtl/replica_pkg.sv
// Shared types for the replica array: city indexing, distance payload and loader FSM states.
package replica_pkg;

  localparam int unsigned city_num_log = 6;
  localparam int unsigned distance_w   = 16;

  typedef logic [distance_w-1:0] distance_data_t;

  // Broadcast write address: row occupies the upper half.
  typedef struct packed {
    logic [city_num_log-1:0] row;
    logic [city_num_log-1:0] col;
  } dis_addr_t;

  typedef enum logic [2:0] {
    IDLE,
    DIAG,
    PAIR_A,
    PAIR_B,
    FIN
  } loader_state_t;

endpackage

// File: rtl/tp_dis_loader.sv
// Loads the symmetric distance table into the node array: writes the zero diagonal,
// then mirrors each upper-triangle stream beat into (i,j) and (j,i).
module tp_dis_loader
  import replica_pkg::*;
#(
  parameter int unsigned city_num = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         running,
  input  distance_data_t               s_tdata,
  input  logic                         s_tvalid,
  output logic                         s_tready,
  input  logic                         s_tlast,
  output logic                         tp_dis_write,
  output logic [city_num_log*2-1:0]    tp_dis_waddr,
  output distance_data_t               tp_dis_wdata,
  output logic                         busy,
  output logic                         done,
  output logic                         tlast_err
);

  localparam int unsigned CW       = city_num_log;
  localparam logic [CW-1:0] LAST_IDX = CW'(city_num - 1);
  localparam logic [CW-1:0] PEN_IDX  = CW'(city_num - 2);

  loader_state_t  state_q, state_d;
  logic [CW-1:0]  k_q, k_d;
  logic [CW-1:0]  i_q, i_d;
  logic [CW-1:0]  j_q, j_d;
  distance_data_t data_q, data_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           write_q, write_d;
  dis_addr_t      waddr_q, waddr_d;
  distance_data_t wdata_q, wdata_d;
  logic           tready_q, tready_d;
  logic           tlast_err_q, tlast_err_d;

  logic accept;
  logic last_pair;

  assign accept    = s_tvalid & tready_q;
  assign last_pair = (i_q == PEN_IDX) && (j_q == LAST_IDX);

  // Next-state, counter advance and registered-output computation.
  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    i_d         = i_q;
    j_d         = j_q;
    data_d      = data_q;
    busy_d      = busy_q;
    tlast_err_d = tlast_err_q;
    done_d      = 1'b0;
    write_d     = 1'b0;
    waddr_d     = '0;
    wdata_d     = '0;

    case (state_q)
      IDLE: begin
        if (start && !running) begin
          k_d         = '0;
          i_d         = '0;
          j_d         = CW'(1);
          tlast_err_d = 1'b0;
          busy_d      = 1'b1;
          state_d     = DIAG;
        end
      end
      DIAG: begin
        write_d = 1'b1;
        waddr_d = '{row: k_q, col: k_q};
        k_d     = k_q + CW'(1);
        if (k_q == LAST_IDX) begin
          state_d = PAIR_A;
        end
      end
      PAIR_A: begin
        if (accept) begin
          write_d = 1'b1;
          waddr_d = '{row: i_q, col: j_q};
          wdata_d = s_tdata;
          data_d  = s_tdata;
          if (s_tlast != last_pair) begin
            tlast_err_d = 1'b1;
          end
          state_d = PAIR_B;
        end
      end
      PAIR_B: begin
        write_d = 1'b1;
        waddr_d = '{row: j_q, col: i_q};
        wdata_d = data_q;
        if (last_pair) begin
          state_d = FIN;
        end else begin
          state_d = PAIR_A;
          if (j_q == LAST_IDX) begin
            i_d = i_q + CW'(1);
            j_d = i_q + CW'(2);
          end else begin
            j_d = j_q + CW'(1);
          end
        end
      end
      FIN: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Ready is registered, so it tracks the state being entered.
    tready_d = (state_d == PAIR_A);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      k_q         <= '0;
      i_q         <= '0;
      j_q         <= '0;
      data_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      write_q     <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      tready_q    <= 1'b0;
      tlast_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      i_q         <= i_d;
      j_q         <= j_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      write_q     <= write_d;
      waddr_q     <= waddr_d;
      wdata_q     <= wdata_d;
      tready_q    <= tready_d;
      tlast_err_q <= tlast_err_d;
    end
  end

  assign s_tready     = tready_q;
  assign tp_dis_write = write_q;
  assign tp_dis_waddr = waddr_q;
  assign tp_dis_wdata = wdata_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign tlast_err    = tlast_err_q;

endmodule

// File: tb/tb_tp_dis_loader.sv
// Bench for tp_dis_loader: a 4-city instance for the main sequences and a 2-city instance
// for the minimum-size case.
module tb_tp_dis_loader;
  import replica_pkg::*;

  typedef struct {
    distance_data_t data;
    int             i;
    int             j;
  } beat_vec_t;

  logic clk;
  logic reset;

  logic           start4, running4, tvalid4, tlast4, tready4, write4, busy4, done4, err4;
  distance_data_t tdata4, wdata4;
  logic [11:0]    waddr4;

  logic           start2, running2, tvalid2, tlast2, tready2, write2, busy2, done2, err2;
  distance_data_t tdata2, wdata2;
  logic [11:0]    waddr2;

  int errors = 0;
  int checks = 0;

  beat_vec_t vec [6];
  beat_vec_t vec2 [4];

  tp_dis_loader #(.city_num(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .running(running4),
    .s_tdata(tdata4), .s_tvalid(tvalid4), .s_tready(tready4), .s_tlast(tlast4),
    .tp_dis_write(write4), .tp_dis_waddr(waddr4), .tp_dis_wdata(wdata4),
    .busy(busy4), .done(done4), .tlast_err(err4)
  );

  tp_dis_loader #(.city_num(2)) u_dut2 (
    .clk(clk), .reset(reset), .start(start2), .running(running2),
    .s_tdata(tdata2), .s_tvalid(tvalid2), .s_tready(tready2), .s_tlast(tlast2),
    .tp_dis_write(write2), .tp_dis_waddr(waddr2), .tp_dis_wdata(wdata2),
    .busy(busy2), .done(done2), .tlast_err(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [11:0] mk(input int r, input int c);
    return {6'(r), 6'(c)};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // Expected n-th write of a 4-city load, derived from the beat table.
  task automatic exp_write(input int n, output logic [11:0] a, output distance_data_t d);
    int p;
    if (n < 4) begin
      a = mk(n, n);
      d = '0;
    end else begin
      p = (n - 4) / 2;
      a = ((n - 4) % 2 == 0) ? mk(vec[p].i, vec[p].j) : mk(vec[p].j, vec[p].i);
      d = vec[p].data;
    end
  endtask

  // One full 4-city load; optional tvalid gaps, mid-load restart pulse and reset after N beats.
  task automatic run_load(input string tag, input logic [5:0] last_mask, input bit gaps,
                          input int restart_cyc, input int rst_beats);
    int  beat = 0;
    int  cyc = 0;
    int  nwr = 0;
    int  ndone = 0;
    int  last_wr_cyc = -1;
    int  done_cyc = -1;
    int  viol = 0;
    bit  pend = 0;
    bit  finished = 0;
    bit  err_exp = 0;
    logic [11:0]    ea;
    distance_data_t ed;

    @(negedge clk);
    start4 = 1'b1; running4 = 1'b0; tvalid4 = 1'b0; tlast4 = 1'b0;
    @(negedge clk);
    start4 = 1'b0;
    chk({tag, " busy_after_start"}, 32'(busy4), 32'd1);
    chk({tag, " err_cleared_by_start"}, 32'(err4), 32'd0);

    while (!finished && cyc < 200) begin
      if (write4) begin
        exp_write(nwr, ea, ed);
        chk($sformatf("%s write%0d addr", tag, nwr), 32'(waddr4), 32'(ea));
        chk($sformatf("%s write%0d data", tag, nwr), 32'(wdata4), 32'(ed));
        nwr++;
        last_wr_cyc = cyc;
      end
      if (done4) begin
        ndone++;
        done_cyc = cyc;
        finished = 1;
        chk({tag, " busy_low_at_done"}, 32'(busy4), 32'd0);
      end
      if (tready4 && !busy4) viol++;
      if (tready4 && write4 && ((waddr4[11:6] < waddr4[5:0]) ||
          (waddr4[11:6] == waddr4[5:0] && waddr4[11:6] != 6'd3))) viol++;

      if (pend) begin
        err_exp = err_exp | (last_mask[beat] != (beat == 5));
        chk($sformatf("%s tlast_err after beat%0d", tag, beat), 32'(err4), 32'(err_exp));
        beat++;
      end

      if (rst_beats > 0 && beat == rst_beats) begin
        #2 reset = 1'b1;
        #1;
        chk({tag, " rst busy"}, 32'(busy4), 32'd0);
        chk({tag, " rst done"}, 32'(done4), 32'd0);
        chk({tag, " rst write"}, 32'(write4), 32'd0);
        chk({tag, " rst tready"}, 32'(tready4), 32'd0);
        tvalid4 = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        return;
      end

      start4 = (cyc == restart_cyc);

      if (beat >= 6) begin
        tvalid4 = 1'b0;
      end else if (!tvalid4 || pend) begin
        tvalid4 = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      tdata4 = (beat < 6) ? vec[beat].data : '0;
      tlast4 = (beat < 6) ? last_mask[beat] : 1'b0;
      pend   = tvalid4 && tready4;

      @(negedge clk);
      cyc++;
    end

    tvalid4 = 1'b0;
    start4  = 1'b0;
    chk({tag, " finished_in_budget"}, 32'(finished), 32'd1);
    chk({tag, " write_count"}, 32'(nwr), 32'd16);
    chk({tag, " done_count"}, 32'(ndone), 32'd1);
    chk({tag, " done_after_last_write"}, 32'(done_cyc), 32'(last_wr_cyc + 1));
    chk({tag, " tlast_err_final"}, 32'(err4), 32'(err_exp));
    chk({tag, " tready_violations"}, 32'(viol), 32'd0);
  endtask

  initial begin
    int n_busy, n_ready, n_wr, n2, cyc2;
    bit pend2, fin2;

    vec[0] = '{data: 16'd10, i: 0, j: 1};
    vec[1] = '{data: 16'd11, i: 0, j: 2};
    vec[2] = '{data: 16'd12, i: 0, j: 3};
    vec[3] = '{data: 16'd13, i: 1, j: 2};
    vec[4] = '{data: 16'd14, i: 1, j: 3};
    vec[5] = '{data: 16'd15, i: 2, j: 3};

    vec2[0] = '{data: 16'd0, i: 0, j: 0};
    vec2[1] = '{data: 16'd0, i: 1, j: 1};
    vec2[2] = '{data: 16'd7, i: 0, j: 1};
    vec2[3] = '{data: 16'd7, i: 1, j: 0};

    reset = 1'b1;
    start4 = 1'b0; running4 = 1'b0; tvalid4 = 1'b0; tlast4 = 1'b0; tdata4 = '0;
    start2 = 1'b0; running2 = 1'b0; tvalid2 = 1'b0; tlast2 = 1'b0; tdata2 = '0;

    @(negedge clk);
    chk("reset outputs4", 32'({busy4, done4, write4, tready4, err4}), 32'd0);
    chk("reset waddr4", 32'(waddr4), 32'd0);
    chk("reset wdata4", 32'(wdata4), 32'd0);
    chk("reset outputs2", 32'({busy2, done2, write2, tready2, err2}), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1: clean load
    run_load("t1", 6'b100000, 1'b0, -1, 0);
    // 2: random tvalid gaps
    run_load("t2", 6'b100000, 1'b1, -1, 0);
    // 3: early tlast on beat 3, then a clean load clears the flag
    run_load("t3", 6'b100100, 1'b0, -1, 0);
    run_load("t3b", 6'b100000, 1'b0, -1, 0);
    // missing tlast on the final pair
    run_load("t3c", 6'b000000, 1'b1, -1, 0);

    // 4: start while running is ignored and the stream is never consumed
    @(negedge clk);
    running4 = 1'b1; start4 = 1'b1; tvalid4 = 1'b1; tdata4 = 16'd99;
    n_busy = 0; n_ready = 0; n_wr = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      start4 = 1'b0;
      if (busy4) n_busy++;
      if (tready4) n_ready++;
      if (write4) n_wr++;
    end
    running4 = 1'b0; tvalid4 = 1'b0;
    chk("t4 busy_while_running", 32'(n_busy), 32'd0);
    chk("t4 tready_while_running", 32'(n_ready), 32'd0);
    chk("t4 writes_while_running", 32'(n_wr), 32'd0);
    // second start mid-load
    run_load("t4b", 6'b100000, 1'b0, 8, 0);

    // 5: reset after beat 2, then a fresh load
    run_load("t5rst", 6'b100000, 1'b0, -1, 2);
    run_load("t5", 6'b100000, 1'b0, -1, 0);

    // 6: two-city instance
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    n2 = 0; cyc2 = 0; pend2 = 0; fin2 = 0;
    while (!fin2 && cyc2 < 50) begin
      if (write2) begin
        if (n2 < 4) begin
          chk($sformatf("t6 write%0d addr", n2), 32'(waddr2), 32'(mk(vec2[n2].i, vec2[n2].j)));
          chk($sformatf("t6 write%0d data", n2), 32'(wdata2), 32'(vec2[n2].data));
        end
        n2++;
      end
      if (done2) fin2 = 1;
      if (pend2) tvalid2 = 1'b0;
      else if (!fin2 && n2 < 3) begin
        tvalid2 = 1'b1; tdata2 = 16'd7; tlast2 = 1'b1;
      end
      pend2 = tvalid2 && tready2;
      @(negedge clk);
      cyc2++;
    end
    tvalid2 = 1'b0;
    chk("t6 done_seen", 32'(fin2), 32'd1);
    chk("t6 write_count", 32'(n2), 32'd4);
    chk("t6 tlast_err", 32'(err2), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
